booth_mult_seq: RTL and testbench

Sequential signed radix-2 Booth multiplier controller. It accepts two WIDE-bit two's-complement operands through a start/ready handshake. It then walks the multiplier one bit per cycle, forming each Booth digit (val = op2[i] ^ op2[i-1] with op2[-1] = 0, sign = op2[i]) and adding or subtracting the shifted multiplicand into a 2*WIDE-bit accumulator. It is the time-multiplexed alternative to the parallel Booth encoder plus adder tree in the multiplier directory, for area-constrained users.

---
 rtl/booth_mult_seq_if.sv | 22 ++
 rtl/booth_mult_seq.sv | 107 ++++++++++
 tb/tb_booth_mult_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Start/ready request and result bundle for the sequential Booth multiplier.
interface booth_mult_seq_if #(
   parameter int unsigned WIDE = 8
);
   logic                  start;
   logic [WIDE-1:0]       op1;
   logic [WIDE-1:0]       op2;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [2*WIDE-1:0]     result;

   modport master (
      output start, op1, op2,
      input  ready, busy, done, result
   );

   modport slave (
      input  start, op1, op2,
      output ready, busy, done, result
   );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one multiplier bit per cycle,
// fixed WIDE-cycle calculation, registered handshake outputs.
module booth_mult_seq #(
   parameter int unsigned WIDE = 8
) (
   input  logic            clk,
   input  logic            rst,
   booth_mult_seq_if.slave bus
);
   localparam int unsigned PW = 2 * WIDE;
   localparam int unsigned CW = (WIDE > 2) ? $clog2(WIDE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          r_state,  w_state_nxt;
   logic [PW-1:0]   r_mcand,  w_mcand_nxt;
   logic [WIDE-1:0] r_mplier, w_mplier_nxt;
   logic            r_prev,   w_prev_nxt;
   logic [PW-1:0]   r_acc,    w_acc_nxt;
   logic [CW-1:0]   r_cnt,    w_cnt_nxt;
   logic [PW-1:0]   r_result, w_result_nxt;
   logic            r_ready,  w_ready_nxt;
   logic            r_busy,   w_busy_nxt;
   logic            r_done,   w_done_nxt;

   // Next-state and datapath: multiplicand shifts left and multiplier shifts
   // right each digit, so digit i always sits at r_mplier[0] / r_mcand.
   always_comb begin
      w_state_nxt  = r_state;
      w_mcand_nxt  = r_mcand;
      w_mplier_nxt = r_mplier;
      w_prev_nxt   = r_prev;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_result_nxt = r_result;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt  = S_CALC;
               w_mcand_nxt  = {{WIDE{bus.op1[WIDE-1]}}, bus.op1};
               w_mplier_nxt = bus.op2;
               w_prev_nxt   = 1'b0;
               w_acc_nxt    = '0;
               w_cnt_nxt    = '0;
            end
         end
         S_CALC: begin
            case ({r_mplier[0], r_prev})
               2'b01:   w_acc_nxt = r_acc + r_mcand;
               2'b10:   w_acc_nxt = r_acc - r_mcand;
               default: w_acc_nxt = r_acc;
            endcase
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_prev_nxt   = r_mplier[0];
            w_cnt_nxt    = r_cnt + CW'(1);
            if (r_cnt == CW'(WIDE - 1)) begin
               w_state_nxt  = S_DONE;
               w_result_nxt = w_acc_nxt;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt  = (w_state_nxt == S_CALC);
      w_done_nxt  = (w_state_nxt == S_DONE);
   end

   // State and datapath registers; flags are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prev   <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mcand  <= w_mcand_nxt;
         r_mplier <= w_mplier_nxt;
         r_prev   <= w_prev_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign bus.ready  = r_ready;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks for booth_mult_seq at WIDE = 8.
module tb_booth_mult_seq;
   localparam int unsigned WIDE = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDE(WIDE)) bus ();

   booth_mult_seq #(.WIDE(WIDE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issue one multiply from IDLE; lat counts negedges after the accepting
   // edge up to and including the one where done is seen (bounded).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] res, output int lat, output int busy_cnt);
      @(negedge clk);
      bus.start = 1'b1; bus.op1 = a; bus.op2 = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 0; busy_cnt = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.done) break;
      end
      res = bus.result;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0;
      repeat (2) @(negedge clk);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", bus.result); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", bus.ready); end
   endtask

   task automatic test_basic();
      logic [15:0] res; int lat; int bc;
      run_op(8'd3, 8'd5, res, lat, bc);
      checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
      checks++; if (res !== 16'h000F) begin errors++; $display("FAIL basic_result got %h want 000F", res); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bus.done); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", bus.ready); end
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (bus.result !== 16'h000F) begin errors++; $display("FAIL idle_result cyc %0d got %h want 000F", i, bus.result); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done cyc %0d got %b want 0", i, bus.done); end
      end
   endtask

   task automatic test_signed_corners();
      logic [7:0]  va [6] = '{8'hFF, 8'h80, 8'h7F, 8'h00, 8'h07, 8'h7F};
      logic [7:0]  vb [6] = '{8'hFF, 8'h80, 8'h80, 8'hB3, 8'hFD, 8'h7F};
      logic [15:0] ve [6] = '{16'h0001, 16'h4000, 16'hC080, 16'h0000, 16'hFFEB, 16'h3F01};
      logic [15:0] res; int lat; int bc;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], res, lat, bc);
         checks++; if (res !== ve[i]) begin errors++; $display("FAIL corner_%0d result got %h want %h", i, res, ve[i]); end
         checks++; if (lat !== 9) begin errors++; $display("FAIL corner_%0d latency got %0d want 9", i, lat); end
      end
   endtask

   task automatic test_ignore_start();
      int lat = 0; int bad_ready = 0; int extra = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op1 = 8'd9; bus.op2 = 8'hFC;   // 9 * -4
      @(posedge clk);
      #1 bus.start = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         bus.start = (lat == 3);
         if (lat == 3) begin bus.op1 = 8'd100; bus.op2 = 8'd100; end
         if (bus.ready) bad_ready++;
         if (bus.done) break;
      end
      bus.start = 1'b0;
      checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", lat); end
      checks++; if (bus.result !== 16'hFFDC) begin errors++; $display("FAIL ignore_result got %h want FFDC", bus.result); end
      checks++; if (bad_ready !== 0) begin errors++; $display("FAIL ignore_ready_high got %0d cycles want 0", bad_ready); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy || bus.done) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_queued_op got %0d active cycles want 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  a, b;
      logic [15:0] expv;
      int n = 0; int cyc = 0; int last = 0;
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      expv = 16'(int'($signed(a)) * int'($signed(b)));
      bus.start = 1'b1; bus.op1 = a; bus.op2 = b;
      while (n < 1000 && cyc < 10200) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            checks++;
            if (bus.result !== expv) begin errors++; $display("FAIL b2b_result #%0d %h*%h got %h want %h", n, a, b, bus.result, expv); end
            if (n > 0) begin
               checks++;
               if (cyc - last !== 10) begin errors++; $display("FAIL b2b_period #%0d got %0d want 10", n, cyc - last); end
            end
            last = cyc;
            n++;
            a = 8'($urandom); b = 8'($urandom);
            expv = 16'(int'($signed(a)) * int'($signed(b)));
            bus.op1 = a; bus.op2 = b;
            if (n == 1000) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      checks++; if (n !== 1000) begin errors++; $display("FAIL b2b_count got %0d want 1000", n); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [15:0] res; int lat; int bc; int stray = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op1 = 8'd3; bus.op2 = 8'd5;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;   // between edges, in the fourth CALC cycle
      #1;
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", bus.ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", bus.done); end
      checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL arst_result got %h want 0000", bus.result); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL arst_stray_activity got %0d want 0", stray); end
      run_op(8'd6, 8'hF9, res, lat, bc);   // 6 * -7
      checks++; if (res !== 16'hFFD6) begin errors++; $display("FAIL arst_new_result got %h want FFD6", res); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL arst_new_latency got %0d want 9", lat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_idle_hold();
      test_signed_corners();
      test_ignore_start();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
